regfile_scan_ctrl: RTL and testbench
====================================

# regfile_scan_ctrl

Sequencer that drives the RISC-I single-cycle register file from the other side of its port interface. On command it either dumps every register as a valid/ready stream, using both read ports, or clears r1..r31 through the write port. It sits between the debug/test-access logic and the register file, muxed onto the register file ports while `o_Busy` is high.

## Interface

Parameters:
- `NUM_REGS`, 32: register count. Must be even, a power of two, and ≤ 2^`ADDR_W`.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `CLEAR_VALUE`, 0: value written in clear mode.

Ports:
- `i_CLK`, in, 1: clock. All state updates on the rising edge.
- `i_RST`, in, 1: synchronous, active-high reset.
- `i_Start`, in, 1: command strobe. Sampled only in IDLE.
- `i_Mode`, in, 1: selects the command, sampled together with `i_Start`. 0 = dump, 1 = clear.
- `o_Busy`, out, 1: high in every state except IDLE.
- `o_Done`, out, 1: one-cycle pulse at command completion.
- `o_Read_Reg_Addr1`, out, `ADDR_W`: to register file read port 1.
- `o_Read_Reg_Addr2`, out, `ADDR_W`: to register file read port 2.
- `i_Read_Reg_Data1`, in, `DATA_W`: combinational read data from port 1.
- `i_Read_Reg_Data2`, in, `DATA_W`: combinational read data from port 2.
- `o_RegWrite`, out, 1: register file write enable.
- `o_Write_Reg_Addr`, out, `ADDR_W`: register file write address.
- `o_Write_Reg_Data`, out, `DATA_W`: register file write data.
- `o_Dump_Valid`, out, 1: dump beat valid.
- `o_Dump_Addr`, out, `ADDR_W`: register index of the current beat.
- `o_Dump_Data`, out, `DATA_W`: register value of the current beat.
- `i_Dump_Ready`, in, 1: sink accepts the beat.

## Operation

States: IDLE, RD, SEND0, SEND1, CLR, DONE. Internal registers: `base` (`ADDR_W`), `waddr` (`ADDR_W`), `buf0` and `buf1` (`DATA_W` each).

State transitions:
- **IDLE:**
  - `i_Start` = 1 and `i_Mode` = 0 → RD, with `base` = 0.
  - `i_Start` = 1 and `i_Mode` = 1 → CLR, with `waddr` = 1.
  - Otherwise stay in IDLE.
- **RD:**
  - Drive `o_Read_Reg_Addr1` = `base` and `o_Read_Reg_Addr2` = `base`+1.
  - At the clock edge, `buf0` ← `i_Read_Reg_Data1` and `buf1` ← `i_Read_Reg_Data2`.
  - → SEND0.
- **SEND0:**
  - `o_Dump_Valid` = 1, `o_Dump_Addr` = `base`, `o_Dump_Data` = `buf0`.
  - `i_Dump_Ready` = 1 → SEND1. Otherwise hold.
- **SEND1:**
  - `o_Dump_Valid` = 1, `o_Dump_Addr` = `base`+1, `o_Dump_Data` = `buf1`.
  - On `i_Dump_Ready` = 1: if `base`+1 = `NUM_REGS`-1 → DONE; else `base` += 2 → RD.
- **CLR:**
  - `o_RegWrite` = 1, `o_Write_Reg_Addr` = `waddr`, `o_Write_Reg_Data` = `CLEAR_VALUE`.
  - If `waddr` = `NUM_REGS`-1 → DONE; else `waddr` += 1.
  - r0 is never written.
- **DONE:** `o_Done` = 1 → IDLE.

Stream and output rules:
- Valid/ready protocol:
  - Once `o_Dump_Valid` is asserted, it stays high and `o_Dump_Addr`/`o_Dump_Data` stay stable until the beat is accepted.
  - A beat is transferred on a clock edge where valid and ready are both high.
  - `o_Dump_Valid` never depends combinationally on `i_Dump_Ready`.
- The dumped value of r0 is whatever the register file returns; no forcing inside this block.
- Read addresses are 0 outside RD.
- `o_RegWrite` is 0 outside CLR. Write address and write data are 0 outside CLR.

## Timing

- Reset values of all outputs are 0: `o_Busy`, `o_Done`, `o_Dump_Valid`, `o_RegWrite`, all addresses and all data. State = IDLE, internal registers = 0.
- A reset asserted mid-command takes effect at the next edge:
  - The command is abandoned and no further write or beat occurs.
  - No `o_Done` pulse is produced.
- `i_Start` asserted while busy is ignored. `i_Start` in the same cycle as `i_RST` is ignored.
- Dump with `i_Dump_Ready` held at 1, start sampled at edge 0:
  - RD in cycle 1, SEND0 in cycle 2, SEND1 in cycle 3. Each register pair takes 3 cycles.
  - Last beat (`NUM_REGS`-1) is in cycle 48.
  - `o_Done` is high in cycle 49.
  - `o_Busy` is high in cycles 1–49.
- Clear, start sampled at edge 0:
  - Writes r1..r31 in cycles 1–31, one per cycle.
  - `o_Done` is high in cycle 32.
- Back-to-back commands:
  - `i_Start` in the `o_Done` cycle is ignored.
  - The earliest accepted start is in the first IDLE cycle after DONE.
- Arithmetic:
  - `base` and `waddr` are `ADDR_W` bits wide. No wrap occurs because termination compares against `NUM_REGS`-1.

## Test plan

- **Reset:** assert `i_RST` for 2 cycles → all outputs 0, `o_Busy` = 0.
- **Clear:** preload r1..r31 = 0xA5A5_0000+i, pulse `i_Start` with `i_Mode` = 1.
  - Exactly 31 write cycles, addresses 1..31, data 0.
  - r0 is never addressed.
  - `o_Done` occurs at cycle 32.
  - A subsequent register file read of r7 returns 0.
- **Dump, ready held at 1:** preload ri = 0x100+i, then dump.
  - Beats 0..31 arrive in order, with data 0x100+i (r0 returns 0).
  - Read addresses are (2k, 2k+1) in each RD cycle.
  - `o_Done` occurs at cycle 49.
- **Dump with backpressure:** `i_Dump_Ready` random at 50%.
  - Same 32 beats arrive in order.
  - Valid, addr and data are held stable while ready = 0.
  - No beat is dropped or duplicated.
- **Start while busy:** pulse `i_Start` with `i_Mode` = 1 at cycle 10 of a dump → ignored; no `o_RegWrite` is ever asserted.
- **Reset mid-command:** assert `i_RST` during the CLR write of r12.
  - No writes occur after the reset edge; r13..r31 are unchanged.
  - No `o_Done` pulse.
  - A new dump after reset starts again at beat 0.

Source files
------------

// File: rtl/regfile_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl_if
//
// Purpose: Bundles every non-clock, non-reset signal of the register-file
//          scan controller into one interface. The signal names keep the
//          controller's own point of view: i_* enter the controller and
//          o_* leave it.
//
// Signal groups:
//   command   : i_Start, i_Mode       -> controller
//               o_Busy, o_Done        <- controller
//   read port : o_Read_Reg_Addr1/2    <- controller
//               i_Read_Reg_Data1/2    -> controller (combinational data)
//   write port: o_RegWrite, o_Write_Reg_Addr, o_Write_Reg_Data <- controller
//   dump      : o_Dump_Valid, o_Dump_Addr, o_Dump_Data <- controller
//               i_Dump_Ready          -> controller
//
// Modports:
//   master : the scan controller itself
//   slave  : the surrounding logic (register file, debug access, dump sink)
// ---------------------------------------------------------------------------
interface regfile_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  // Command / status
  logic              i_Start;
  logic              i_Mode;
  logic              o_Busy;
  logic              o_Done;

  // Register file read ports
  logic [ADDR_W-1:0] o_Read_Reg_Addr1;
  logic [ADDR_W-1:0] o_Read_Reg_Addr2;
  logic [DATA_W-1:0] i_Read_Reg_Data1;
  logic [DATA_W-1:0] i_Read_Reg_Data2;

  // Register file write port
  logic              o_RegWrite;
  logic [ADDR_W-1:0] o_Write_Reg_Addr;
  logic [DATA_W-1:0] o_Write_Reg_Data;

  // Dump stream
  logic              o_Dump_Valid;
  logic [ADDR_W-1:0] o_Dump_Addr;
  logic [DATA_W-1:0] o_Dump_Data;
  logic              i_Dump_Ready;

  modport master (
    input  i_Start,
    input  i_Mode,
    output o_Busy,
    output o_Done,
    output o_Read_Reg_Addr1,
    output o_Read_Reg_Addr2,
    input  i_Read_Reg_Data1,
    input  i_Read_Reg_Data2,
    output o_RegWrite,
    output o_Write_Reg_Addr,
    output o_Write_Reg_Data,
    output o_Dump_Valid,
    output o_Dump_Addr,
    output o_Dump_Data,
    input  i_Dump_Ready
  );

  modport slave (
    output i_Start,
    output i_Mode,
    input  o_Busy,
    input  o_Done,
    input  o_Read_Reg_Addr1,
    input  o_Read_Reg_Addr2,
    output i_Read_Reg_Data1,
    output i_Read_Reg_Data2,
    input  o_RegWrite,
    input  o_Write_Reg_Addr,
    input  o_Write_Reg_Data,
    input  o_Dump_Valid,
    input  o_Dump_Addr,
    input  o_Dump_Data,
    output i_Dump_Ready
  );

endinterface

// File: rtl/regfile_scan_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl
//
// Purpose: Sequencer that drives a single-cycle register file from the far
//          side of its ports. On a start command it either
//            - dumps every register as a valid/ready stream, reading two
//              registers per visit through both read ports, or
//            - clears r1..r31 through the write port (r0 is never written).
//          It is muxed onto the register file ports while o_Busy is high.
//
// Ports:
//   i_CLK : clock, all state changes on the rising edge
//   i_RST : synchronous, active-high reset
//   bus   : regfile_scan_ctrl_if.master carrying command/status, the two
//           read ports, the write port and the dump stream
//
// Every output is a flop. Output next-values are decoded from the next
// state (and next base/waddr/buffers), so each output is valid in the same
// cycle as the state it belongs to, with no combinational path from any
// input to any output (in particular o_Dump_Valid never follows
// i_Dump_Ready combinationally).
// ---------------------------------------------------------------------------
module regfile_scan_ctrl #(
  parameter int                NUM_REGS    = 32,
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  regfile_scan_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
    S_CLR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_ADDR   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_ADDR    = ADDR_W'(2);
  // Both loops terminate by comparing against the last index, so base and
  // waddr never need to hold NUM_REGS itself and never wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] ZERO_DATA   = {DATA_W{1'b0}};

  // -------------------------------------------------------------------------
  // State and internal registers
  // -------------------------------------------------------------------------
  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] base_q,   base_d;    // even index of the current pair
  logic [ADDR_W-1:0] waddr_q,  waddr_d;   // register being cleared
  logic [DATA_W-1:0] buf0_q,   buf0_d;    // value of r[base]
  logic [DATA_W-1:0] buf1_q,   buf1_d;    // value of r[base+1]

  // Registered outputs
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic [ADDR_W-1:0] rd_addr1_q,   rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q,   rd_addr2_d;
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic              dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0] dump_addr_q,  dump_addr_d;
  logic [DATA_W-1:0] dump_data_q,  dump_data_d;

  // Next-state logic for the sequencer and its working registers
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_Start) begin
          if (bus.i_Mode) begin
            state_d = S_CLR;
            waddr_d = ONE_ADDR;   // r0 is hard-wired; clearing starts at r1
          end else begin
            state_d = S_RD;
            base_d  = ZERO_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD: begin
        // Read addresses are already on the port; capture the pair.
        buf0_d  = bus.i_Read_Reg_Data1;
        buf1_d  = bus.i_Read_Reg_Data2;
        state_d = S_SEND0;
      end

      S_SEND0: begin
        if (bus.i_Dump_Ready) begin
          state_d = S_SEND1;
        end else begin
          state_d = S_SEND0;
        end
      end

      S_SEND1: begin
        if (bus.i_Dump_Ready) begin
          if ((base_q + ONE_ADDR) == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            base_d  = base_q + TWO_ADDR;
            state_d = S_RD;
          end
        end else begin
          state_d = S_SEND1;
        end
      end

      S_CLR: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          waddr_d = waddr_q + ONE_ADDR;
          state_d = S_CLR;
        end
      end

      S_DONE: begin
        // A start seen here is dropped: commands are accepted in IDLE only.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs line up with their state
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = 1'b0;
    rd_addr1_d   = ZERO_ADDR;
    rd_addr2_d   = ZERO_ADDR;
    reg_write_d  = 1'b0;
    wr_addr_d    = ZERO_ADDR;
    wr_data_d    = ZERO_DATA;
    dump_valid_d = 1'b0;
    dump_addr_d  = ZERO_ADDR;
    dump_data_d  = ZERO_DATA;

    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end

      S_RD: begin
        rd_addr1_d = base_d;
        rd_addr2_d = base_d + ONE_ADDR;
      end

      S_SEND0: begin
        // While ready is low the state, base and buf0 are unchanged, so the
        // beat is re-registered with identical contents.
        dump_valid_d = 1'b1;
        dump_addr_d  = base_d;
        dump_data_d  = buf0_d;
      end

      S_SEND1: begin
        dump_valid_d = 1'b1;
        dump_addr_d  = base_d + ONE_ADDR;
        dump_data_d  = buf1_d;
      end

      S_CLR: begin
        reg_write_d = 1'b1;
        wr_addr_d   = waddr_d;
        wr_data_d   = CLEAR_VALUE;
      end

      S_DONE: begin
        done_d = 1'b1;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, working registers and output flops with synchronous reset
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q      <= S_IDLE;
      base_q       <= ZERO_ADDR;
      waddr_q      <= ZERO_ADDR;
      buf0_q       <= ZERO_DATA;
      buf1_q       <= ZERO_DATA;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_addr1_q   <= ZERO_ADDR;
      rd_addr2_q   <= ZERO_ADDR;
      reg_write_q  <= 1'b0;
      wr_addr_q    <= ZERO_ADDR;
      wr_data_q    <= ZERO_DATA;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= ZERO_ADDR;
      dump_data_q  <= ZERO_DATA;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      waddr_q      <= waddr_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_addr1_q   <= rd_addr1_d;
      rd_addr2_q   <= rd_addr2_d;
      reg_write_q  <= reg_write_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign bus.o_Busy           = busy_q;
  assign bus.o_Done           = done_q;
  assign bus.o_Read_Reg_Addr1 = rd_addr1_q;
  assign bus.o_Read_Reg_Addr2 = rd_addr2_q;
  assign bus.o_RegWrite       = reg_write_q;
  assign bus.o_Write_Reg_Addr = wr_addr_q;
  assign bus.o_Write_Reg_Data = wr_data_q;
  assign bus.o_Dump_Valid     = dump_valid_q;
  assign bus.o_Dump_Addr      = dump_addr_q;
  assign bus.o_Dump_Data      = dump_data_q;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_scan_ctrl
//
// Directed bench for regfile_scan_ctrl with a behavioural single-cycle
// register file (r0 reads as zero, combinational reads, clocked write) and a
// scoreboard queue of expected dump beats.
// ---------------------------------------------------------------------------
module tb_regfile_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  regfile_scan_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus_if ();

  regfile_scan_ctrl #(
    .NUM_REGS   (32),
    .ADDR_W     (5),
    .DATA_W     (32),
    .CLEAR_VALUE(32'h0000_0000)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural register file
  logic [31:0] rf     [32];
  logic [31:0] img    [32];
  logic [31:0] exp_rf [32];
  logic        pre_ld = 1'b0;

  always @(posedge clk) begin
    if (pre_ld) begin
      for (int i = 0; i < 32; i++) rf[i] <= img[i];
    end else if (bus_if.o_RegWrite && bus_if.o_Write_Reg_Addr != 5'd0) begin
      rf[bus_if.o_Write_Reg_Addr] <= bus_if.o_Write_Reg_Data;
    end
  end

  assign bus_if.i_Read_Reg_Data1 = (bus_if.o_Read_Reg_Addr1 == 5'd0) ? 32'd0 : rf[bus_if.o_Read_Reg_Addr1];
  assign bus_if.i_Read_Reg_Data2 = (bus_if.o_Read_Reg_Addr2 == 5'd0) ? 32'd0 : rf[bus_if.o_Read_Reg_Addr2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  bus_if.o_Busy, 0);
    check({tag, "_done"},  bus_if.o_Done, 0);
    check({tag, "_valid"}, bus_if.o_Dump_Valid, 0);
    check({tag, "_we"},    bus_if.o_RegWrite, 0);
    check({tag, "_ra1"},   bus_if.o_Read_Reg_Addr1, 0);
    check({tag, "_ra2"},   bus_if.o_Read_Reg_Addr2, 0);
    check({tag, "_wa"},    bus_if.o_Write_Reg_Addr, 0);
    check({tag, "_wd"},    bus_if.o_Write_Reg_Data, 0);
    check({tag, "_da"},    bus_if.o_Dump_Addr, 0);
    check({tag, "_dd"},    bus_if.o_Dump_Data, 0);
  endtask

  // sel 0: ri = 0xA5A5_0000+i, sel 1: ri = 0x100+i
  task automatic preload(input bit sel);
    for (int i = 0; i < 32; i++) begin
      img[i]    = sel ? (32'h0000_0100 + 32'(i)) : (32'hA5A5_0000 + 32'(i));
      exp_rf[i] = (i == 0) ? 32'd0 : img[i];
    end
    @(negedge clk); pre_ld = 1'b1;
    @(negedge clk); pre_ld = 1'b0;
  endtask

  task automatic run_dump(input bit bp, input bit poke);
    int cyc = 0, beats = 0;
    bit done_seen = 1'b0, holding = 1'b0;
    logic [4:0]  h_addr = 5'd0;
    logic [31:0] h_data = 32'd0;
    logic [36:0] e;
    sb_q.delete();
    for (int i = 0; i < 32; i++) sb_q.push_back({5'(i), exp_rf[i]});
    @(negedge clk);
    bus_if.i_Start = 1'b1; bus_if.i_Mode = 1'b0; bus_if.i_Dump_Ready = 1'b1;
    while (!done_seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      bus_if.i_Start      = (poke && cyc == 10);
      bus_if.i_Mode       = poke;
      bus_if.i_Dump_Ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check("dump_busy", bus_if.o_Busy, 1);
      check("dump_no_write", bus_if.o_RegWrite, 0);
      if (holding) begin
        check("hold_valid", bus_if.o_Dump_Valid, 1);
        check("hold_addr", bus_if.o_Dump_Addr, h_addr);
        check("hold_data", bus_if.o_Dump_Data, h_data);
      end
      if (bus_if.o_Done) begin
        done_seen = 1'b1;
        if (!bp) check("dump_done_cycle", cyc, 49);
      end else if (bus_if.o_Dump_Valid) begin
        if (bus_if.i_Dump_Ready) begin
          holding = 1'b0;
          check("dump_sb_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("beat_addr", bus_if.o_Dump_Addr, e[36:32]);
            check("beat_data", bus_if.o_Dump_Data, e[31:0]);
          end
          beats++;
        end else begin
          holding = 1'b1;
          h_addr  = bus_if.o_Dump_Addr;
          h_data  = bus_if.o_Dump_Data;
        end
      end else begin
        holding = 1'b0;
        check("rd_addr1", bus_if.o_Read_Reg_Addr1, 2 * (beats / 2));
        check("rd_addr2", bus_if.o_Read_Reg_Addr2, 2 * (beats / 2) + 1);
      end
    end
    bus_if.i_Start = 1'b0;
    check("dump_done_seen", done_seen, 1);
    check("dump_beats", beats, 32);
    check("dump_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    check("dump_after_busy", bus_if.o_Busy, 0);
    check("dump_after_we", bus_if.o_RegWrite, 0);
  endtask

  task automatic run_clear();
    int cyc = 0, writes = 0;
    int exp_wa = 1;
    bit done_seen = 1'b0;
    @(negedge clk);
    bus_if.i_Start = 1'b1; bus_if.i_Mode = 1'b1;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus_if.i_Start = 1'b0;
      check("clr_no_valid", bus_if.o_Dump_Valid, 0);
      if (bus_if.o_RegWrite) begin
        check("clr_addr", bus_if.o_Write_Reg_Addr, exp_wa);
        check("clr_data", bus_if.o_Write_Reg_Data, 0);
        exp_wa++;
        writes++;
      end
      if (bus_if.o_Done) begin
        done_seen = 1'b1;
        check("clr_done_cycle", cyc, 32);
      end
    end
    check("clr_done_seen", done_seen, 1);
    check("clr_writes", writes, 31);
    @(negedge clk);
    check("clr_after_busy", bus_if.o_Busy, 0);
    check("clr_r7_zero", rf[7], 0);
    check("clr_r31_zero", rf[31], 0);
    for (int i = 1; i < 32; i++) exp_rf[i] = 32'd0;
  endtask

  task automatic run_clear_reset();
    int cyc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    bus_if.i_Start = 1'b1; bus_if.i_Mode = 1'b1;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus_if.i_Start = 1'b0;
      if (bus_if.o_RegWrite && bus_if.o_Write_Reg_Addr == 5'd12) begin
        seen = 1'b1;
        rst  = 1'b1;
      end
    end
    check("rstmid_r12_seen", seen, 1);
    @(negedge clk);
    check_idle("rstmid");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("rstmid_no_write", bus_if.o_RegWrite, 0);
      check("rstmid_no_done", bus_if.o_Done, 0);
    end
    check("rstmid_r11_zero", rf[11], 0);
    for (int i = 13; i < 32; i++) check("rstmid_keep", rf[i], 32'hA5A5_0000 + 32'(i));
    for (int i = 1; i <= 12; i++) exp_rf[i] = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_Start      = 1'b1;   // start during reset must be ignored
    bus_if.i_Mode       = 1'b0;
    bus_if.i_Dump_Ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    bus_if.i_Start = 1'b0;
    @(negedge clk);
    check("post_reset_busy", bus_if.o_Busy, 0);

    preload(1'b0);
    run_clear();

    preload(1'b1);
    run_dump(1'b0, 1'b0);
    run_dump(1'b1, 1'b0);
    run_dump(1'b0, 1'b1);

    preload(1'b0);
    run_clear_reset();
    run_dump(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
